// File: rtl/song_sequencer.sv
// Note recorder/player: captures received note codes into an external synchronous RAM,
// then replays them as note_start pulses paced by the envelope generator, gaps and rests.
module song_sequencer #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 8,
    parameter int GAP_CYCLES  = 0,
    parameter int REST_CYCLES = 1000,
    parameter int LOOP        = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode_press,
    input  logic              rx_dv,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              env_done,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              note_start,
    output logic              writing,
    output logic              playing,
    output logic [ADDR_W:0]   song_len,
    output logic              overflow
);

    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int CNT_MAX = (GAP_CYCLES > REST_CYCLES) ? GAP_CYCLES : REST_CYCLES;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [ADDR_W:0]   DEPTH_V   = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0]  REST_LOAD = CNT_W'(REST_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REC,
        S_FETCH,
        S_START,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   rd_idx_reg, rd_idx_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [ADDR_W:0]     song_len_reg, song_len_next;
    logic                overflow_reg, overflow_next;
    logic                advance;
    logic                enter_rec;
    logic                last_note;

    assign last_note = (({1'b0, rd_idx_reg} + (ADDR_W + 1)'(1)) >= song_len_reg);

    always_comb begin
        state_next    = state_reg;
        rd_idx_next   = rd_idx_reg;
        cnt_next      = cnt_reg;
        song_len_next = song_len_reg;
        overflow_next = overflow_reg;
        mem_we        = 1'b0;
        mem_addr      = rd_idx_reg;
        note_start    = 1'b0;
        advance       = 1'b0;
        enter_rec     = 1'b0;

        case (state_reg)
            S_IDLE: begin
                mem_addr = '0;
                if (mode_press) enter_rec = 1'b1;
            end
            S_REC: begin
                mem_addr = song_len_reg[ADDR_W-1:0];
                if (rx_dv) begin
                    if (song_len_reg < DEPTH_V) begin
                        mem_we        = 1'b1;
                        song_len_next = song_len_reg + (ADDR_W + 1)'(1);
                    end else begin
                        overflow_next = 1'b1;
                    end
                end
                // A byte arriving with the press is counted before deciding to play.
                if (mode_press) begin
                    if (song_len_next != '0) begin
                        state_next  = S_FETCH;
                        rd_idx_next = '0;
                    end else begin
                        state_next  = S_IDLE;
                    end
                end
            end
            S_FETCH: begin
                if (mode_press) enter_rec = 1'b1;
                else            state_next = S_START;
            end
            S_START: begin
                if (mode_press) begin
                    enter_rec = 1'b1;
                end else if (mem_dout != '0) begin
                    note_start = 1'b1;
                    state_next = S_WAIT;
                end else begin
                    cnt_next   = REST_LOAD;
                    state_next = S_HOLD;
                end
            end
            S_WAIT: begin
                if (mode_press) begin
                    enter_rec = 1'b1;
                end else if (env_done) begin
                    if (GAP_CYCLES == 0) begin
                        advance = 1'b1;
                    end else begin
                        cnt_next   = GAP_LOAD;
                        state_next = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                // The count is consumed one per cycle; the cycle holding 1 is the last one.
                if (mode_press) begin
                    enter_rec = 1'b1;
                end else if (cnt_reg <= CNT_W'(1)) begin
                    cnt_next = '0;
                    advance  = 1'b1;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: state_next = S_IDLE;
        endcase

        if (advance) begin
            if (!last_note) begin
                rd_idx_next = rd_idx_reg + ADDR_W'(1);
                state_next  = S_FETCH;
            end else if (LOOP != 0) begin
                rd_idx_next = '0;
                state_next  = S_FETCH;
            end else begin
                state_next  = S_IDLE;
            end
        end

        if (enter_rec) begin
            state_next    = S_REC;
            song_len_next = '0;
            overflow_next = 1'b0;
        end

        // Reset must also veto any write or pulse in the very cycle it is asserted.
        if (reset) begin
            mem_we     = 1'b0;
            note_start = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            rd_idx_reg   <= '0;
            cnt_reg      <= '0;
            song_len_reg <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            rd_idx_reg   <= rd_idx_next;
            cnt_reg      <= cnt_next;
            song_len_reg <= song_len_next;
            overflow_reg <= overflow_next;
        end
    end

    assign mem_din  = rx_data;
    assign writing  = (state_reg == S_REC);
    assign playing  = (state_reg inside {S_FETCH, S_START, S_WAIT, S_HOLD});
    assign song_len = song_len_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboard bench: two sequencers (looping and one-shot) share stimulus; expected writes and
// note starts are scheduled arithmetically from the song contents and random envelope delays.
module tb_song_sequencer;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int GAP    = 4;
    localparam int REST   = 10;

    logic clk = 1'b0;
    logic reset, mode_press, rx_dv, env_done;
    logic [DATA_W-1:0] rx_data;

    logic              we_a, we_b, ns_a, ns_b, wr_a, wr_b, pl_a, pl_b, ov_a, ov_b;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [DATA_W-1:0] din_a, din_b, dout_a, dout_b;
    logic [ADDR_W:0]   len_a, len_b;
    logic [DATA_W-1:0] mem_a [DEPTH];
    logic [DATA_W-1:0] mem_b [DEPTH];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        bit note;
        int cyc;
        int addr;
        int data;
    } ev_t;

    ev_t exp_a[$];
    ev_t exp_b[$];

    bit mp_at[int];
    bit env_at[int];
    bit rst_at[int];
    int rx_at[int];

    always #5 clk = ~clk;

    song_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .GAP_CYCLES(GAP),
                     .REST_CYCLES(REST), .LOOP(1)) dut_a (
        .clk(clk), .reset(reset), .mode_press(mode_press), .rx_dv(rx_dv),
        .rx_data(rx_data), .env_done(env_done), .mem_dout(dout_a),
        .mem_we(we_a), .mem_addr(addr_a), .mem_din(din_a), .note_start(ns_a),
        .writing(wr_a), .playing(pl_a), .song_len(len_a), .overflow(ov_a)
    );

    song_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .GAP_CYCLES(GAP),
                     .REST_CYCLES(REST), .LOOP(0)) dut_b (
        .clk(clk), .reset(reset), .mode_press(mode_press), .rx_dv(rx_dv),
        .rx_data(rx_data), .env_done(env_done), .mem_dout(dout_b),
        .mem_we(we_b), .mem_addr(addr_b), .mem_din(din_b), .note_start(ns_b),
        .writing(wr_b), .playing(pl_b), .song_len(len_b), .overflow(ov_b)
    );

    // Synchronous-read note memories, one per sequencer.
    always @(posedge clk) begin
        if (we_a) mem_a[addr_a] <= din_a;
        dout_a <= mem_a[addr_a];
        if (we_b) mem_b[addr_b] <= din_b;
        dout_b <= mem_b[addr_b];
    end

    // Driver: applies the scheduled inputs 1 time unit after each rising edge.
    initial begin
        reset = 1'b1; mode_press = 1'b0; rx_dv = 1'b0; rx_data = '0; env_done = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            reset      = rst_at.exists(cyc);
            mode_press = mp_at.exists(cyc);
            env_done   = env_at.exists(cyc);
            rx_dv      = rx_at.exists(cyc);
            rx_data    = '0;
            if (rx_dv) rx_data = DATA_W'(rx_at[cyc]);
        end
    end

    task automatic compare_ev(input int which, input bit note, input int addr, input int data);
        ev_t   e;
        string nm;
        string kind;
        nm   = (which == 0) ? "a" : "b";
        kind = note ? "note" : "write";
        total++;
        if ((which == 0 && exp_a.size() == 0) || (which == 1 && exp_b.size() == 0)) begin
            bad++;
            $display("FAIL unexpected_%s dut=%s cyc=%0d got addr=%0d data=%02h, want no event",
                     kind, nm, cyc, addr, data);
            return;
        end
        if (which == 0) e = exp_a.pop_front();
        else            e = exp_b.pop_front();
        if (e.note != note || e.cyc != cyc || e.addr != addr || e.data != data) begin
            bad++;
            $display("FAIL event_%s dut=%s got %s cyc=%0d addr=%0d data=%02h, want %s cyc=%0d addr=%0d data=%02h",
                     kind, nm, kind, cyc, addr, data, e.note ? "note" : "write", e.cyc, e.addr, e.data);
        end else begin
            $display("dut=%s %s cyc=%0d addr=%0d data=%02h ok", nm, kind, cyc, addr, data);
        end
    endtask

    // Monitor: pops the scoreboard whenever either sequencer writes or starts a note.
    initial begin
        forever begin
            @(negedge clk);
            if (we_a) compare_ev(0, 1'b0, int'(addr_a), int'(din_a));
            if (ns_a) compare_ev(0, 1'b1, int'(addr_a), int'(dout_a));
            if (we_b) compare_ev(1, 1'b0, int'(addr_b), int'(din_b));
            if (ns_b) compare_ev(1, 1'b1, int'(addr_b), int'(dout_b));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d got no finish, want finish", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic wait_cyc(input int c);
        wait (cyc >= c);
        #2;
    endtask

    task automatic chk(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, want);
        end
    endtask

    task automatic push_write(input int c, input int addr, input int data);
        ev_t e;
        e.note = 1'b0; e.cyc = c; e.addr = addr; e.data = data;
        exp_a.push_back(e);
        exp_b.push_back(e);
    endtask

    task automatic push_note(input bit to_b, input int c, input int addr, input int data);
        ev_t e;
        e.note = 1'b1; e.cyc = c; e.addr = addr; e.data = data;
        exp_a.push_back(e);
        if (to_b) exp_b.push_back(e);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_writing_a"}, int'(wr_a), 0);   chk({tag, "_writing_b"}, int'(wr_b), 0);
        chk({tag, "_playing_a"}, int'(pl_a), 0);   chk({tag, "_playing_b"}, int'(pl_b), 0);
        chk({tag, "_song_len_a"}, int'(len_a), 0); chk({tag, "_song_len_b"}, int'(len_b), 0);
        chk({tag, "_overflow_a"}, int'(ov_a), 0);  chk({tag, "_overflow_b"}, int'(ov_b), 0);
        chk({tag, "_mem_addr_a"}, int'(addr_a), 0); chk({tag, "_mem_addr_b"}, int'(addr_b), 0);
        chk({tag, "_note_start_a"}, int'(ns_a), 0); chk({tag, "_note_start_b"}, int'(ns_b), 0);
        chk({tag, "_mem_we_a"}, int'(we_a), 0);    chk({tag, "_mem_we_b"}, int'(we_b), 0);
    endtask

    // Record n bytes from IDLE, play past the end of the song (A loops, B stops),
    // abort in the START slot after, then leave the empty REC back to IDLE.
    // mode 0: 0x41.. with 50-cycle envelopes; 1: random with a rest at index 1; 2: random.
    task automatic song_round(input int n, input int mode, input bit same_cycle);
        int b[DEPTH];
        int t0, c, tm, s, kk, idx, d, b_idle;
        t0 = cyc + 2;
        b_idle = 0;
        mp_at[t0] = 1'b1;
        c = t0 + 1 + $urandom_range(0, 2);
        for (int i = 0; i < n; i++) begin
            if (mode == 0)                b[i] = 'h41 + i;
            else if (mode == 1 && i == 1) b[i] = 0;
            else if ($urandom_range(0, 3) == 0) b[i] = 0;
            else                          b[i] = $urandom_range(1, 255);
            rx_at[c] = b[i];
            push_write(c, i, b[i]);
            if (i < n - 1) c = c + 1 + $urandom_range(0, 2);
        end
        tm = same_cycle ? c : c + 1 + $urandom_range(0, 1);
        mp_at[tm] = 1'b1;
        s  = tm + 2;
        kk = n + 1 + $urandom_range(0, n);
        for (int k = 0; k < kk; k++) begin
            idx = k % n;
            if (b[idx] != 0) begin
                push_note(k < n, s, idx, b[idx]);
                d = (mode == 0) ? 50 : $urandom_range(1, 8);
                env_at[s + d]     = 1'b1;
                env_at[s + d + 2] = 1'b1;   // lands inside the gap hold; must be ignored
                s = s + d + GAP + 2;
            end else begin
                env_at[s + 3] = 1'b1;       // lands inside the rest hold; must be ignored
                s = s + REST + 2;
            end
            if (k == n - 1) b_idle = s - 1;
        end
        mp_at[s]     = 1'b1;
        mp_at[s + 2] = 1'b1;

        wait_cyc(t0 + 1);
        chk("rec_entry_writing_a", int'(wr_a), 1);  chk("rec_entry_writing_b", int'(wr_b), 1);
        chk("rec_entry_song_len_a", int'(len_a), 0); chk("rec_entry_overflow_a", int'(ov_a), 0);
        wait_cyc(tm + 1);
        chk("fetch_playing_a", int'(pl_a), 1);      chk("fetch_playing_b", int'(pl_b), 1);
        chk("fetch_song_len_a", int'(len_a), n);    chk("fetch_song_len_b", int'(len_b), n);
        chk("fetch_mem_addr_a", int'(addr_a), 0);
        wait_cyc(b_idle);
        chk("oneshot_done_playing_b", int'(pl_b), 0);
        chk("oneshot_done_writing_b", int'(wr_b), 0);
        chk("loop_still_playing_a", int'(pl_a), 1);
        wait_cyc(s + 1);
        chk("abort_writing_a", int'(wr_a), 1);      chk("abort_writing_b", int'(wr_b), 1);
        chk("abort_song_len_a", int'(len_a), 0);    chk("abort_playing_a", int'(pl_a), 0);
        wait_cyc(s + 3);
        chk("empty_rec_writing_a", int'(wr_a), 0);  chk("empty_rec_playing_a", int'(pl_a), 0);
        chk("empty_rec_writing_b", int'(wr_b), 0);  chk("empty_rec_playing_b", int'(pl_b), 0);
    endtask

    task automatic overflow_round();
        int t0, c_end, tm;
        t0 = cyc + 2;
        mp_at[t0] = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            rx_at[t0 + 1 + i] = $urandom_range(1, 255);
            if (i < DEPTH) push_write(t0 + 1 + i, i, rx_at[t0 + 1 + i]);
        end
        c_end = t0 + DEPTH + 2;
        tm = c_end + 2;
        rx_at[tm] = 'h5a;          // full: neither written nor counted
        mp_at[tm]     = 1'b1;
        mp_at[tm + 1] = 1'b1;      // abort from FETCH back into REC
        mp_at[tm + 3] = 1'b1;      // empty REC returns to IDLE
        wait_cyc(c_end + 1);
        chk("full_song_len_a", int'(len_a), DEPTH); chk("full_song_len_b", int'(len_b), DEPTH);
        chk("full_overflow_a", int'(ov_a), 1);      chk("full_overflow_b", int'(ov_b), 1);
        wait_cyc(tm + 1);
        chk("full_fetch_playing_a", int'(pl_a), 1); chk("full_fetch_overflow_a", int'(ov_a), 1);
        wait_cyc(tm + 2);
        chk("reenter_overflow_a", int'(ov_a), 0);   chk("reenter_overflow_b", int'(ov_b), 0);
        chk("reenter_song_len_a", int'(len_a), 0);  chk("reenter_writing_a", int'(wr_a), 1);
        wait_cyc(tm + 4);
        chk("ovf_idle_writing_a", int'(wr_a), 0);   chk("ovf_idle_playing_b", int'(pl_b), 0);
    endtask

    initial begin
        int t0, tm;
        rst_at[1] = 1'b1; rst_at[2] = 1'b1; rst_at[3] = 1'b1;
        wait_cyc(4);
        chk_idle("after_reset");

        song_round(3, 0, 1'b0);
        song_round($urandom_range(3, DEPTH), 1, 1'b0);
        overflow_round();
        song_round($urandom_range(2, DEPTH), 2, 1'b1);
        song_round(1, 2, 1'b0);

        // Reset while waiting for the envelope of the first note.
        t0 = cyc + 2;
        mp_at[t0] = 1'b1;
        rx_at[t0 + 1] = 'h11; push_write(t0 + 1, 0, 'h11);
        rx_at[t0 + 2] = 'h22; push_write(t0 + 2, 1, 'h22);
        tm = t0 + 3;
        mp_at[tm] = 1'b1;
        push_note(1'b1, tm + 2, 0, 'h11);
        rst_at[tm + 4] = 1'b1;
        wait_cyc(tm + 4);
        chk("wait_before_reset_playing_a", int'(pl_a), 1);
        wait_cyc(tm + 5);
        chk_idle("reset_in_wait");

        // Reset together with mode_press and a byte in REC: nothing written.
        t0 = cyc + 2;
        mp_at[t0] = 1'b1;
        rx_at[t0 + 1] = 'h33; push_write(t0 + 1, 0, 'h33);
        rx_at[t0 + 3] = 'h44;
        mp_at[t0 + 3] = 1'b1;
        rst_at[t0 + 3] = 1'b1;
        wait_cyc(t0 + 3);
        chk("reset_rec_mem_we_a", int'(we_a), 0);
        chk("reset_rec_mem_we_b", int'(we_b), 0);
        wait_cyc(t0 + 4);
        chk_idle("reset_in_rec");

        wait_cyc(cyc + 20);
        chk("leftover_events_a", exp_a.size(), 0);
        chk("leftover_events_b", exp_b.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
